// File: rtl/core_stage_sequencer.sv
// core_stage_sequencer
// Walks the enabled subset of the eight core_top compute stages (Q_GEN..FFN1)
// in ascending order. For each stage it programs control_state with a
// control_state_update pulse, waits SETTLE_CYC cycles, pulses core_start,
// waits for core_finish and reports the measured stage cycle count.
//
// Optional feature: define SEQ_WATCHDOG_EN to enable the per-stage watchdog
// (timeout_cyc, seq_err, err_stage). Without it timeout_cyc is ignored and
// seq_err / err_stage are tied low.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   seq_start, seq_abort  sequence start pulse / abort level
//   stage_mask            bit i enables stage code i+1 (sampled on start)
//   timeout_cyc           watchdog limit, 0 = off (sampled on start)
//   seq_busy, seq_done    sequence status
//   seq_err, err_stage    watchdog error flag and offending stage code
//   control_state(_update), core_start, core_finish   core_top handshake
//   stat_vld, stat_stage, stat_cycles                  per-stage result
module core_stage_sequencer #(
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned TIMEOUT_W  = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 seq_start,
  input  logic                 seq_abort,
  input  logic [7:0]           stage_mask,
  input  logic [TIMEOUT_W-1:0] timeout_cyc,
  output logic                 seq_busy,
  output logic                 seq_done,
  output logic                 seq_err,
  output logic [3:0]           err_stage,
  output logic [31:0]          control_state,
  output logic                 control_state_update,
  output logic                 core_start,
  input  logic                 core_finish,
  output logic                 stat_vld,
  output logic [3:0]           stat_stage,
  output logic [CNT_W-1:0]     stat_cycles
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StPick   = 3'd1;
  localparam logic [2:0] StUpdate = 3'd2;
  localparam logic [2:0] StSettle = 3'd3;
  localparam logic [2:0] StStart  = 3'd4;
  localparam logic [2:0] StWait   = 3'd5;
  localparam logic [2:0] StReport = 3'd6;
  localparam logic [2:0] StDone   = 3'd7;

  logic [2:0]       state_q, state_d;
  logic [7:0]       pend_q, pend_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      settle_q, settle_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] stat_cycles_q, stat_cycles_d;
  logic [2:0]       low_idx;
  logic [3:0]       cur_stage, next_stage;
  logic             timeout_hit;

  assign cur_stage  = {1'b0, idx_q} + 4'd1;
  assign next_stage = {1'b0, idx_d} + 4'd1;
  assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign stat_cycles = stat_cycles_q;

`ifdef SEQ_WATCHDOG_EN
  localparam int unsigned CmpW = (CNT_W > TIMEOUT_W) ? CNT_W : TIMEOUT_W;

  logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
  logic                 err_q, err_d;
  logic [3:0]           err_stage_q, err_stage_d;

  // Compare against the incremented count so the limit covers this cycle.
  assign timeout_hit = (timeout_q != '0) && (CmpW'(cnt_inc) == CmpW'(timeout_q));
  assign seq_err     = err_q;
  assign err_stage   = err_stage_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_cyc;
  assign timeout_hit    = 1'b0;
  assign seq_err        = 1'b0;
  assign err_stage      = 4'd0;
`endif

  // Lowest pending stage wins: scan downwards so the last hit is the lowest.
  always_comb begin
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pend_q[i]) low_idx = 3'(i);
    end
  end

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    idx_d         = idx_q;
    settle_d      = settle_q;
    cnt_d         = cnt_q;
    stat_cycles_d = stat_cycles_q;
`ifdef SEQ_WATCHDOG_EN
    timeout_d     = timeout_q;
    err_d         = err_q;
    err_stage_d   = err_stage_q;
`endif
    if (seq_abort && (state_q != StIdle) && (state_q != StDone)) begin
      // Abort overrides any finish/timeout this cycle: no stat, no error.
      state_d = StDone;
    end else begin
      case (state_q)
        StIdle: begin
          if (seq_start) begin
            pend_d      = stage_mask;
`ifdef SEQ_WATCHDOG_EN
            timeout_d   = timeout_cyc;
            err_d       = 1'b0;
            err_stage_d = 4'd0;
`endif
            state_d     = StPick;
          end
        end
        StPick: begin
          if (pend_q == 8'd0) begin
            state_d = StDone;
          end else begin
            idx_d   = low_idx;
            state_d = StUpdate;
          end
        end
        StUpdate: begin
          settle_d = 32'd0;
          state_d  = StSettle;
        end
        StSettle: begin
          if (settle_q == SETTLE_CYC - 1) state_d = StStart;
          else settle_d = settle_q + 32'd1;
        end
        StStart: begin
          cnt_d   = '0;
          state_d = StWait;
        end
        StWait: begin
          cnt_d = cnt_inc;
          if (core_finish) begin
            stat_cycles_d = cnt_inc;
            state_d       = StReport;
          end else if (timeout_hit) begin
`ifdef SEQ_WATCHDOG_EN
            err_d       = 1'b1;
            err_stage_d = cur_stage;
`endif
            state_d     = StDone;
          end
        end
        StReport: begin
          pend_d[idx_q] = 1'b0;
          state_d       = StPick;
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are registered from the next state so each pulse lines up with
  // the cycle the FSM occupies the corresponding state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q              <= StIdle;
      pend_q               <= 8'd0;
      idx_q                <= 3'd0;
      settle_q             <= 32'd0;
      cnt_q                <= '0;
      stat_cycles_q        <= '0;
      seq_busy             <= 1'b0;
      seq_done             <= 1'b0;
      control_state        <= 32'd0;
      control_state_update <= 1'b0;
      core_start           <= 1'b0;
      stat_vld             <= 1'b0;
      stat_stage           <= 4'd0;
`ifdef SEQ_WATCHDOG_EN
      timeout_q            <= '0;
      err_q                <= 1'b0;
      err_stage_q          <= 4'd0;
`endif
    end else begin
      state_q              <= state_d;
      pend_q               <= pend_d;
      idx_q                <= idx_d;
      settle_q             <= settle_d;
      cnt_q                <= cnt_d;
      stat_cycles_q        <= stat_cycles_d;
      seq_busy             <= (state_d != StIdle);
      seq_done             <= (state_d == StDone);
      control_state_update <= (state_d == StUpdate) || (state_d == StDone);
      core_start           <= (state_d == StStart);
      stat_vld             <= (state_d == StReport);
      if (state_d == StUpdate) control_state <= 32'(next_stage);
      else if (state_d == StDone) control_state <= 32'd0;
      if (state_d == StReport) stat_stage <= cur_stage;
`ifdef SEQ_WATCHDOG_EN
      timeout_q            <= timeout_d;
      err_q                <= err_d;
      err_stage_q          <= err_stage_d;
`endif
    end
  end

endmodule

// File: doc/core_stage_sequencer.md
# core_stage_sequencer

Stage sequencer for `core_top`. It walks the enabled subset of the eight compute stages (Q_GEN..FFN1) in order. For each stage it programs `control_state`/`control_state_update`, pulses `start`, waits for `finish` under an optional watchdog, and reports a per-stage cycle count. It sits between the system-level control/CSR logic and one `core_top` instance, replacing manual stage pushing.

## Interface
- `SETTLE_CYC`, 1: idle cycles between the `control_state_update` pulse and `core_start`; legal range ≥1.
- `CNT_W`, 32: width of the per-stage cycle counter.
- `TIMEOUT_W`, 20: width of the watchdog limit.

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `seq_start`  in  1  pulse; begins a sequence; ignored while `seq_busy`=1
- `seq_abort`  in  1  level; forces the sequence to end
- `stage_mask`  in  8  bit i enables stage code i+1; sampled on an accepted `seq_start`
- `timeout_cyc`  in  TIMEOUT_W  watchdog limit in cycles, 0 = disabled; sampled with `stage_mask`
- `seq_busy`  out  1  high from the cycle after an accepted `seq_start` through the DONE cycle
- `seq_done`  out  1  one-cycle pulse at sequence end
- `seq_err`  out  1  timeout flag; sticky until the next accepted `seq_start`
- `err_stage`  out  4  stage code that timed out (0 = none)
- `control_state`  out  32  stage code driven to `core_top`
- `control_state_update`  out  1  one-cycle pulse to `core_top`
- `core_start`  out  1  one-cycle pulse to `core_top.start`
- `core_finish`  in  1  from `core_top.finish`
- `stat_vld`  out  1  one-cycle pulse; stage result is valid
- `stat_stage`  out  4  stage code for the reported result
- `stat_cycles`  out  CNT_W  measured stage cycles

## Operation
- Stage codes: IDLE=0, Q_GEN=1, K_GEN=2, V_GEN=3, ATT_QK=4, ATT_PV=5, PROJ=6, FFN0=7, FFN1=8.
- Reset values: every output is 0 and the FSM is in IDLE.
- FSM states: IDLE, PICK, UPDATE, SETTLE, START, WAIT, REPORT, DONE.
- **IDLE**
  - On `seq_start`: latch the mask into `pend_mask`, latch `timeout_cyc`, clear `seq_err` and `err_stage`, go to PICK.
- **PICK**
  - If `pend_mask`=0, go to DONE.
  - Otherwise select the lowest set bit i, set `cur_stage`=i+1, go to UPDATE.
- **UPDATE**
  - Drive `control_state`=`cur_stage` and `control_state_update`=1 for this cycle.
  - Go to SETTLE. `control_state` holds its value until changed.
- **SETTLE**
  - Stay for `SETTLE_CYC` cycles, then go to START.
- **START**
  - Drive `core_start`=1, clear the counter to 0, go to WAIT.
- **WAIT**
  - Counter increments by 1 each cycle, saturating at all-ones.
  - `core_finish`=1 → go to REPORT; `stat_cycles` = counter value including the current cycle, so finish in the first WAIT cycle gives 1.
  - Watchdog: if it is enabled, `timeout_cyc`≠0, and the incremented count equals `timeout_cyc` without finish → set `seq_err`=1 and `err_stage`=`cur_stage`, go to DONE. Remaining stages are skipped.
  - If finish and timeout happen in the same cycle, finish wins.
- **REPORT**
  - Pulse `stat_vld` with `stat_stage`=`cur_stage` and `stat_cycles`.
  - Clear bit `cur_stage`-1 in `pend_mask`, go to PICK.
- **DONE**
  - Drive `control_state`=0 and `control_state_update`=1, pulse `seq_done`, go to IDLE.
- `seq_abort`=1 in any state except IDLE or DONE: next state is DONE. The interrupted stage produces no `stat_vld`, and `seq_err` is not set.
- `core_finish` is ignored outside WAIT.
- `rst` mid-sequence returns everything to reset values on the next edge. `core_top` is not notified.

## Timing
- All outputs are registered.
- Accepted `seq_start` at edge T:
  - PICK at T+1.
  - `control_state_update` at T+2.
  - `core_start` at T+3+`SETTLE_CYC`.
- Stage-to-stage gap: `core_finish` at cycle F → `stat_vld` at F+1, next `control_state_update` at F+3.
- Mask=0: `seq_done` at T+2. This is the DONE cycle, with `control_state_update` to IDLE.
- Timeout: `seq_done` one cycle after the WAIT cycle in which the count reached `timeout_cyc`.

## Configuration
- Macro `SEQ_WATCHDOG_EN`.
- Defined: timeout logic, `seq_err` and `err_stage` behave as specified above.
- Undefined: `timeout_cyc` is ignored, WAIT exits only on finish or abort, and `seq_err`/`err_stage` are tied 0. The cycle counter and stats remain.

## Test plan
- Mask 8'hFF, model `core_finish` 10 cycles after each `core_start`:
  - Eight `stat_vld` pulses, stages 1..8 in order, each with `stat_cycles`=10.
  - One `seq_done`, `control_state` back to 0.
- Mask 8'b1000_0101:
  - `control_state_update` values in order are 1, 3, 8, then 0.
  - `core_start` occurs exactly 3 times.
- Mask 0:
  - `seq_done` two cycles after `seq_start`.
  - No `core_start` and no `stat_vld`.
- Watchdog: `timeout_cyc`=50, stage 4 never finishes:
  - `seq_err`=1, `err_stage`=4, no `stat_vld` for stage 4, stages 5..8 skipped.
  - With the macro undefined, the FSM stays in WAIT until abort.
- `seq_abort` during WAIT of stage 2:
  - `seq_done` next cycle, `seq_err`=0, no stage-2 stat.
- Stray and simultaneous events:
  - `seq_start` while busy is ignored, and the sequence result is unchanged.
  - `core_finish` in IDLE is ignored.
  - `core_finish` on the same cycle the count hits `timeout_cyc`: stat reported, no error.
- `rst` asserted in SETTLE: all outputs 0 on the next cycle, FSM in IDLE, and a new `seq_start` works normally.
